// File: rtl/dht11_pkg.sv
// Shared types and defaults for the DHT11 responder emulator.
// Optional checksum corruption is controlled by the DHT_CHKSUM_INJ_EN macro in the top.
package dht11_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DETECT_LOW,
        ST_RESP_DLY,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW,
        ST_COOLDOWN
    } state_t;

    // Default phase lengths in 50 MHz clock cycles.
    localparam int unsigned DEF_START_MIN_CYC = 400_000;
    localparam int unsigned DEF_RESP_DLY_CYC  = 1_500;
    localparam int unsigned DEF_RESP_LOW_CYC  = 4_000;
    localparam int unsigned DEF_RESP_HIGH_CYC = 4_000;
    localparam int unsigned DEF_BIT_LOW_CYC   = 2_500;
    localparam int unsigned DEF_BIT0_HIGH_CYC = 1_300;
    localparam int unsigned DEF_BIT1_HIGH_CYC = 3_500;
    localparam int unsigned DEF_COOLDOWN_CYC  = 50_000;

    localparam int unsigned FRAME_BITS     = 40;
    localparam int unsigned HUM_INT_OFS    = 0;
    localparam int unsigned HUM_FLOAT_OFS  = 8;
    localparam int unsigned TEMP_INT_OFS   = 16;
    localparam int unsigned TEMP_FLOAT_OFS = 24;
    localparam int unsigned CHKSUM_OFS     = 32;

    // Bit 0 of the packed frame is the first bit on the wire (hum_int LSB).
    typedef struct packed {
        logic [7:0] chksum;
        logic [7:0] temp_float;
        logic [7:0] temp_int;
        logic [7:0] hum_float;
        logic [7:0] hum_int;
    } frame_t;

    function automatic logic [7:0] checksum(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        return 8'(a + b + c + d);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dht11_sensor_emulator_od_pad.sv
// Open-drain pad for the single-wire bus plus a 2-FF synchronizer on the line input.
module dht_od_pad (
    input  logic clk,
    input  logic rst_n,
    input  logic drive_low,
    inout  wire  pad,
    output logic line_sync
);

    logic meta;

    assign pad = drive_low ? 1'b0 : 1'bz;

    // Reset to 1 so an idle pulled-up bus never looks like a start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            meta      <= pad;
            line_sync <= meta;
        end
    end

endmodule

// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor responder: detects the host start pulse and replies with a 40-bit frame.
// Define DHT_CHKSUM_INJ_EN to let inj_err corrupt the checksum of the next frame.
module dht11_sensor_emulator
    import dht11_pkg::*;
#(
    parameter int unsigned START_MIN_CYC = DEF_START_MIN_CYC,
    parameter int unsigned RESP_DLY_CYC  = DEF_RESP_DLY_CYC,
    parameter int unsigned RESP_LOW_CYC  = DEF_RESP_LOW_CYC,
    parameter int unsigned RESP_HIGH_CYC = DEF_RESP_HIGH_CYC,
    parameter int unsigned BIT_LOW_CYC   = DEF_BIT_LOW_CYC,
    parameter int unsigned BIT0_HIGH_CYC = DEF_BIT0_HIGH_CYC,
    parameter int unsigned BIT1_HIGH_CYC = DEF_BIT1_HIGH_CYC,
    parameter int unsigned COOLDOWN_CYC  = DEF_COOLDOWN_CYC
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_float,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_float,
    input  logic       inj_err,
    inout  wire        dht_line,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned MAX_CYC = max_u(
        max_u(max_u(START_MIN_CYC, RESP_DLY_CYC), max_u(RESP_LOW_CYC, RESP_HIGH_CYC)),
        max_u(max_u(BIT_LOW_CYC, BIT0_HIGH_CYC), max_u(BIT1_HIGH_CYC, COOLDOWN_CYC)));
    localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;
    localparam int unsigned IDX_W = 6;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    frame_t                 frame_q, frame_d;
    logic                   drive_q, drive_d;
    logic                   busy_d, done_d;
    logic                   line_sync;
    logic [FRAME_BITS-1:0]  frame_bits;
    logic [7:0]             chk_flip;

    dht_od_pad u_pad (
        .clk       (clock),
        .rst_n     (reset),
        .drive_low (drive_q),
        .pad       (dht_line),
        .line_sync (line_sync)
    );

`ifdef DHT_CHKSUM_INJ_EN
    assign chk_flip = {7'b0, inj_err};
`else
    logic unused_inj_err;
    assign unused_inj_err = inj_err;
    assign chk_flip       = 8'h00;
`endif

    assign frame_bits = frame_q;

    // Next-state, counter, bit index and frame latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable && !line_sync) state_d = ST_DETECT_LOW;
            end
            ST_DETECT_LOW: begin
                if (!line_sync) begin
                    if (cnt_q == CNT_SAT) cnt_d = cnt_q;
                end else begin
                    cnt_d = '0;
                    if (cnt_q >= CNT_W'(START_MIN_CYC)) begin
                        state_d           = ST_RESP_DLY;
                        frame_d.hum_int    = hum_int;
                        frame_d.hum_float  = hum_float;
                        frame_d.temp_int   = temp_int;
                        frame_d.temp_float = temp_float;
                        frame_d.chksum     = checksum(hum_int, hum_float, temp_int, temp_float)
                                             ^ chk_flip;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP_DLY: if (cnt_q == CNT_W'(RESP_DLY_CYC - 1)) begin
                cnt_d   = '0;
                state_d = ST_RESP_LOW;
            end
            ST_RESP_LOW: if (cnt_q == CNT_W'(RESP_LOW_CYC - 1)) begin
                cnt_d   = '0;
                state_d = ST_RESP_HIGH;
            end
            ST_RESP_HIGH: if (cnt_q == CNT_W'(RESP_HIGH_CYC - 1)) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_BIT_LOW;
            end
            ST_BIT_LOW: if (cnt_q == CNT_W'(BIT_LOW_CYC - 1)) begin
                cnt_d   = '0;
                state_d = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                if (cnt_q == (frame_bits[idx_q] ? CNT_W'(BIT1_HIGH_CYC - 1)
                                                : CNT_W'(BIT0_HIGH_CYC - 1))) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
                        state_d = ST_END_LOW;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_BIT_LOW;
                    end
                end
            end
            ST_END_LOW: if (cnt_q == CNT_W'(BIT_LOW_CYC - 1)) begin
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = ST_COOLDOWN;
            end
            ST_COOLDOWN: if (cnt_q == CNT_W'(COOLDOWN_CYC - 1)) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs registered from the next state so the pad tracks the state exactly.
    always_comb begin
        drive_d = state_d inside {ST_RESP_LOW, ST_BIT_LOW, ST_END_LOW};
        busy_d  = !(state_d inside {ST_IDLE, ST_DETECT_LOW});
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            drive_q    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            drive_q    <= drive_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Self-checking bench for dht11_sensor_emulator with shortened phase lengths and a host-reader model.
module tb_dht11_sensor_emulator;

    localparam int T_START = 40;
    localparam int T_DLY   = 15;
    localparam int T_RLO   = 40;
    localparam int T_RHI   = 40;
    localparam int T_BLO   = 25;
    localparam int T_B0    = 13;
    localparam int T_B1    = 35;
    localparam int T_CD    = 100;
    localparam int LIMIT   = 400;
`ifdef DHT_CHKSUM_INJ_EN
    localparam bit INJ_ON = 1'b1;
`else
    localparam bit INJ_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] hi;
        logic [7:0] hf;
        logic [7:0] ti;
        logic [7:0] tf;
        logic       inj;
        logic [7:0] chk;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       inj_err = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] hum_int = 8'h00, hum_float = 8'h00, temp_int = 8'h00, temp_float = 8'h00;
    logic       busy, frame_done;
    wire        dht_line;

    int n_cmp = 0;
    int n_bad = 0;
    logic [39:0] sb_q[$];
    vec_t vecs[5];

    pullup (dht_line);
    assign dht_line = host_low ? 1'b0 : 1'bz;

    always #5 clock = ~clock;

    dht11_sensor_emulator #(
        .START_MIN_CYC (T_START), .RESP_DLY_CYC (T_DLY), .RESP_LOW_CYC (T_RLO),
        .RESP_HIGH_CYC (T_RHI), .BIT_LOW_CYC (T_BLO), .BIT0_HIGH_CYC (T_B0),
        .BIT1_HIGH_CYC (T_B1), .COOLDOWN_CYC (T_CD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .hum_int    (hum_int),
        .hum_float  (hum_float),
        .temp_int   (temp_int),
        .temp_float (temp_float),
        .inj_err    (inj_err),
        .dht_line   (dht_line),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Count consecutive negedges on which the bus sits at lvl.
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (dht_line === lvl && n < LIMIT) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic host_start(input int cycles);
        @(negedge clock);
        host_low = 1'b1;
        repeat (cycles) @(negedge clock);
        host_low = 1'b0;
    endtask

    task automatic watch_quiet(input string name);
        int lows = 0;
        int busys = 0;
        repeat (120) begin
            @(negedge clock);
            if (dht_line !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        check({name, "_line_low"}, 64'(lows), 64'd0);
        check({name, "_busy"}, 64'(busys), 64'd0);
    endtask

    // Host-reader model: checks every phase length and decodes the 40 bits.
    task automatic read_frame(input int abort_bit, input int drop_en_bit);
        logic [39:0] got;
        logic [39:0] exp;
        int n, lo, hi, bad_lo, bad_hi;
        got = '0;
        bad_lo = 0;
        bad_hi = 0;
        @(negedge clock);
        measure(1'b1, n);
        check("resp_delay", 64'(n), 64'(T_DLY + 2));
        check("busy_in_resp", 64'(busy), 64'd1);
        // Inputs are latched at acceptance; changing them now must not alter the frame.
        hum_int = ~hum_int;
        temp_float = temp_float + 8'd3;
        measure(1'b0, n);
        check("resp_low", 64'(n), 64'(T_RLO));
        measure(1'b1, n);
        check("resp_high", 64'(n), 64'(T_RHI));
        for (int i = 0; i < 40; i++) begin
            if (i == drop_en_bit) enable = 1'b0;
            if (i == abort_bit) begin
                repeat (3) @(negedge clock);
                reset = 1'b0;
                #1;
                check("abort_line_released", 64'(dht_line), 64'd1);
                check("abort_busy", 64'(busy), 64'd0);
                @(negedge clock);
                check("abort_line_held", 64'(dht_line), 64'd1);
                reset = 1'b1;
                void'(sb_q.pop_front());
                return;
            end
            measure(1'b0, lo);
            measure(1'b1, hi);
            got[i] = (hi > (T_B0 + T_B1) / 2);
            if (lo != T_BLO) bad_lo++;
            if (hi != (got[i] ? T_B1 : T_B0)) bad_hi++;
        end
        measure(1'b0, n);
        check("end_low", 64'(n), 64'(T_BLO));
        check("frame_done_pulse", 64'(frame_done), 64'd1);
        @(negedge clock);
        check("frame_done_clear", 64'(frame_done), 64'd0);
        n = 1;
        while (busy === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clock);
        end
        check("cooldown_len", 64'(n), 64'(T_CD));
        check("bit_low_errs", 64'(bad_lo), 64'd0);
        check("bit_high_errs", 64'(bad_hi), 64'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check("frame_bits", 64'(got), 64'(exp));
        end
    endtask

    task automatic send(input vec_t v, input int abort_bit, input int drop_en_bit);
        logic [7:0] chk;
        hum_int    = v.hi;
        hum_float  = v.hf;
        temp_int   = v.ti;
        temp_float = v.tf;
        inj_err    = v.inj;
        chk = (INJ_ON && v.inj) ? (v.chk ^ 8'h01) : v.chk;
        sb_q.push_back({chk, v.tf, v.ti, v.hf, v.hi});
        host_start(60);
        read_frame(abort_bit, drop_en_bit);
        inj_err = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{hi: 8'h37, hf: 8'h00, ti: 8'h19, tf: 8'h05, inj: 1'b0, chk: 8'h55};
        vecs[1] = '{hi: 8'hFF, hf: 8'hFF, ti: 8'hFF, tf: 8'hFF, inj: 1'b0, chk: 8'hFC};
        vecs[2] = '{hi: 8'h00, hf: 8'h00, ti: 8'h00, tf: 8'h00, inj: 1'b0, chk: 8'h00};
        vecs[3] = '{hi: 8'h12, hf: 8'h34, ti: 8'h56, tf: 8'h78, inj: 1'b0, chk: 8'h14};
        vecs[4] = '{hi: 8'h37, hf: 8'h00, ti: 8'h19, tf: 8'h05, inj: 1'b1, chk: 8'h55};

        enable = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_line", 64'(dht_line), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 5; i++) send(vecs[i], -1, -1);

        // Short host low is a glitch: no reply, busy never rises.
        host_start(10);
        watch_quiet("glitch");

        // Disabled responder ignores a valid start pulse.
        enable = 1'b0;
        host_start(60);
        watch_quiet("disabled");
        enable = 1'b1;

        // Dropping enable mid-frame must not cut the frame short.
        send(vecs[3], -1, 5);
        enable = 1'b1;

        // Reset during bit 20, then a fresh full frame.
        send(vecs[1], 20, -1);
        repeat (5) @(negedge clock);
        check("after_abort_busy", 64'(busy), 64'd0);
        send(vecs[0], -1, -1);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
